// File: rtl/sdram_arbit.sv
// SDRAM command arbiter and periodic auto-refresh engine in front of the read/write engines.
// Optional `SDRAM_ARB_RD_PRIO_EN: read wins over write in arbitration (refresh always first).
module sdram_arbit #(
    parameter int REF_CYCLES = 780,
    parameter int T_RP       = 2,
    parameter int T_RFC      = 7
) (
    input  logic        s_clk,
    input  logic        s_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        en_wr,
    output logic        en_rd,
    output logic        req_aref,
    output logic        aref_miss,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_bank
);

    localparam int AREF_LEN = 3 + T_RP + 2 * T_RFC;
    localparam int REF_W    = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam int AREF_W   = $clog2(AREF_LEN);

    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REF_CYCLES - 1);
    localparam logic [AREF_W-1:0] AREF_LAST = AREF_W'(AREF_LEN - 1);
    localparam logic [AREF_W-1:0] AREF_AR1  = AREF_W'(1 + T_RP);
    localparam logic [AREF_W-1:0] AREF_AR2  = AREF_W'(2 + T_RP + T_RFC);

    localparam logic [3:0]  CMD_NOP   = 4'b0111;
    localparam logic [3:0]  CMD_PRE   = 4'b0010;
    localparam logic [3:0]  CMD_AREF  = 4'b0001;
    localparam logic [11:0] ADDR_PALL = 12'b0100_0000_0000;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARB   = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [REF_W-1:0]    ref_cnt;
    logic [AREF_W-1:0]   cnt_aref;
    logic                ref_wrap;
    logic                aref_done;

    assign ref_wrap  = init_end && (ref_cnt == REF_LAST);
    assign aref_done = (state == ST_AREF) && (cnt_aref == AREF_LAST);

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (init_end) state_nxt = ST_ARB;
            ST_ARB: begin
                if (req_aref) begin
                    state_nxt = ST_AREF;
`ifdef SDRAM_ARB_RD_PRIO_EN
                end else if (rd_req) begin
                    state_nxt = ST_READ;
                end else if (wr_req) begin
                    state_nxt = ST_WRITE;
`else
                end else if (wr_req) begin
                    state_nxt = ST_WRITE;
                end else if (rd_req) begin
                    state_nxt = ST_READ;
`endif
                end
            end
            ST_AREF:  if (aref_done) state_nxt = ST_ARB;
            ST_WRITE: if (wr_end) state_nxt = ST_ARB;
            ST_READ:  if (rd_end) state_nxt = ST_ARB;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Refresh interval timer stays parked at zero until initialisation finishes.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n || !init_end) begin
            ref_cnt <= '0;
        end else if (ref_wrap) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            cnt_aref <= '0;
        end else if ((state == ST_AREF) && !aref_done) begin
            cnt_aref <= cnt_aref + 1'b1;
        end else begin
            cnt_aref <= '0;
        end
    end

    // A wrap landing on the AREF exit edge keeps the request set so refresh repeats.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            req_aref  <= 1'b0;
            aref_miss <= 1'b0;
        end else begin
            if (ref_wrap) begin
                req_aref <= 1'b1;
            end else if (aref_done) begin
                req_aref <= 1'b0;
            end
            if (ref_wrap && req_aref) begin
                aref_miss <= 1'b1;
            end
        end
    end

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            ST_AREF: begin
                if (cnt_aref == '0) begin
                    sdram_cmd  = CMD_PRE;
                    sdram_addr = ADDR_PALL;
                end else if ((cnt_aref == AREF_AR1) || (cnt_aref == AREF_AR2)) begin
                    sdram_cmd = CMD_AREF;
                end
            end
            default: ;
        endcase
    end

    assign en_wr     = (state == ST_WRITE);
    assign en_rd     = (state == ST_READ);
    assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: vector table, directed refresh/reset sequences,
// and a randomized run scored against a behavioural arbiter model.
module tb_sdram_arbit;

    localparam int REF_CYCLES = 780;
    localparam int T_RP       = 2;
    localparam int T_RFC      = 7;
    localparam int AREF_LEN   = 3 + T_RP + 2 * T_RFC;
`ifdef SDRAM_ARB_RD_PRIO_EN
    localparam bit RD_PRIO = 1'b1;
`else
    localparam bit RD_PRIO = 1'b0;
`endif

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [3:0]  INIT_CMD_C  = 4'b1000;
    localparam logic [11:0] INIT_ADDR_C = 12'h5A5;
    localparam logic [3:0]  WR_CMD_C    = 4'b0100;
    localparam logic [11:0] WR_ADDR_C   = 12'h123;
    localparam logic [1:0]  WR_BANK_C   = 2'd1;
    localparam logic [3:0]  RD_CMD_C    = 4'b0101;
    localparam logic [11:0] RD_ADDR_C   = 12'h456;
    localparam logic [1:0]  RD_BANK_C   = 2'd2;

    localparam int SEL_INIT = 0, SEL_NOP = 1, SEL_HI = 2, SEL_LO = 3;
    localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic        s_clk = 1'b0;
    logic        s_rst_n, init_end;
    logic [3:0]  init_cmd, wr_cmd, rd_cmd;
    logic [11:0] init_addr, wr_addr, rd_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic        wr_req, wr_end, rd_req, rd_end;
    logic        en_wr, en_rd, req_aref, aref_miss, sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_bank;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;

    sdram_arbit #(.REF_CYCLES(REF_CYCLES), .T_RP(T_RP), .T_RFC(T_RFC)) dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .en_wr(en_wr), .en_rd(en_rd), .req_aref(req_aref), .aref_miss(aref_miss),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
    );

    always #5 s_clk = ~s_clk;
    always @(posedge s_clk) cyc <= cyc + 1;

    typedef struct {
        bit rst_n, init_end, hi_req, hi_end, lo_req, lo_end, restart;
        bit exp_en_hi, exp_en_lo;
        int sel;
    } vec_t;

    vec_t vecs[16];

    // Behavioural reference: who owns the bus, cycles since the timer started, refresh step.
    int  m_owner   = O_INIT;
    int  m_elapsed = 0;
    int  m_ref_pos = 0;
    bit  m_pend    = 1'b0;
    bit  m_miss    = 1'b0;
    logic [3:0] aref_seq [AREF_LEN];

    function automatic bit mWrap();
        return init_end && ((m_elapsed % REF_CYCLES) == REF_CYCLES - 1);
    endfunction

    function automatic bit mRefDone();
        return (m_owner == O_REF) && (m_ref_pos == AREF_LEN - 1);
    endfunction

    function automatic int mNextOwner();
        bit first_req, second_req;
        first_req  = RD_PRIO ? rd_req : wr_req;
        second_req = RD_PRIO ? wr_req : rd_req;
        case (m_owner)
            O_INIT: return init_end ? O_IDLE : O_INIT;
            O_IDLE: begin
                if (m_pend) return O_REF;
                if (first_req) return RD_PRIO ? O_RD : O_WR;
                if (second_req) return RD_PRIO ? O_WR : O_RD;
                return O_IDLE;
            end
            O_REF:  return mRefDone() ? O_IDLE : O_REF;
            O_WR:   return wr_end ? O_IDLE : O_WR;
            default: return rd_end ? O_IDLE : O_RD;
        endcase
    endfunction

    always @(posedge s_clk) begin
        if (!s_rst_n) begin
            m_owner   <= O_INIT;
            m_elapsed <= 0;
            m_ref_pos <= 0;
            m_pend    <= 1'b0;
            m_miss    <= 1'b0;
        end else begin
            m_owner   <= mNextOwner();
            m_pend    <= mWrap() ? 1'b1 : (mRefDone() ? 1'b0 : m_pend);
            m_miss    <= m_miss | (mWrap() & m_pend);
            m_elapsed <= init_end ? m_elapsed + 1 : 0;
            m_ref_pos <= ((m_owner == O_REF) && !mRefDone()) ? m_ref_pos + 1 : 0;
        end
    end

    function automatic logic [3:0] expCmd();
        case (m_owner)
            O_INIT:  return init_cmd;
            O_REF:   return aref_seq[m_ref_pos];
            O_WR:    return wr_cmd;
            O_RD:    return rd_cmd;
            default: return CMD_NOP;
        endcase
    endfunction

    function automatic logic [11:0] expAddr();
        case (m_owner)
            O_INIT:  return init_addr;
            O_REF:   return (m_ref_pos == 0) ? 12'h400 : 12'h000;
            O_WR:    return wr_addr;
            O_RD:    return rd_addr;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [1:0] expBank();
        return (m_owner == O_WR) ? wr_bank : ((m_owner == O_RD) ? rd_bank : 2'd0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic nextCycle();
        @(posedge s_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge s_clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        s_rst_n  = v.rst_n;
        init_end = v.init_end;
        if (RD_PRIO) begin
            rd_req = v.hi_req; rd_end = v.hi_end; wr_req = v.lo_req; wr_end = v.lo_end;
        end else begin
            wr_req = v.hi_req; wr_end = v.hi_end; rd_req = v.lo_req; rd_end = v.lo_end;
        end
    endtask

    task automatic setConstClients();
        init_cmd = INIT_CMD_C; init_addr = INIT_ADDR_C;
        wr_cmd = WR_CMD_C; wr_addr = WR_ADDR_C; wr_bank = WR_BANK_C;
        rd_cmd = RD_CMD_C; rd_addr = RD_ADDR_C; rd_bank = RD_BANK_C;
    endtask

    // Steps until the named pin condition shows up or the budget runs out.
    task automatic waitReqAref(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            sample();
            if (req_aref === 1'b1) begin
                found = 1'b1;
                break;
            end
            nextCycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        bit hold_ok;
        logic [3:0]  hi_cmd, lo_cmd, e_cmd;
        logic [11:0] hi_addr, lo_addr, e_addr;
        logic [1:0]  hi_bank, lo_bank, e_bank;

        for (int i = 0; i < AREF_LEN; i++) begin
            if (i == 0) aref_seq[i] = CMD_PRE;
            else if (i == 1 + T_RP || i == 2 + T_RP + T_RFC) aref_seq[i] = CMD_AREF;
            else aref_seq[i] = CMD_NOP;
        end

        //            rst ie hr he lr le rs  ehi elo sel
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 0, SEL_INIT};
        vecs[1]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, SEL_INIT};
        vecs[2]  = '{1, 1, 1, 0, 1, 0, 0,  0, 0, SEL_NOP};
        vecs[3]  = '{1, 1, 1, 0, 1, 0, 0,  1, 0, SEL_HI};
        vecs[4]  = '{1, 1, 1, 1, 1, 0, 0,  1, 0, SEL_HI};
        vecs[5]  = '{1, 1, 0, 0, 1, 0, 0,  0, 0, SEL_NOP};
        vecs[6]  = '{1, 1, 0, 0, 1, 0, 0,  0, 1, SEL_LO};
        vecs[7]  = '{1, 1, 0, 0, 1, 1, 0,  0, 1, SEL_LO};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, SEL_NOP};
        vecs[9]  = '{1, 1, 1, 0, 0, 0, 0,  0, 0, SEL_NOP};
        vecs[10] = '{1, 1, 1, 0, 0, 0, 0,  1, 0, SEL_HI};
        vecs[11] = '{0, 1, 1, 0, 0, 0, 0,  1, 0, SEL_HI};
        vecs[12] = '{1, 1, 1, 0, 0, 0, 1,  0, 0, SEL_INIT};
        vecs[13] = '{1, 1, 1, 0, 0, 0, 0,  0, 0, SEL_NOP};
        vecs[14] = '{1, 1, 0, 1, 0, 0, 0,  1, 0, SEL_HI};
        vecs[15] = '{1, 1, 0, 0, 0, 0, 0,  0, 0, SEL_NOP};

        hi_cmd  = RD_PRIO ? RD_CMD_C  : WR_CMD_C;
        hi_addr = RD_PRIO ? RD_ADDR_C : WR_ADDR_C;
        hi_bank = RD_PRIO ? RD_BANK_C : WR_BANK_C;
        lo_cmd  = RD_PRIO ? WR_CMD_C  : RD_CMD_C;
        lo_addr = RD_PRIO ? WR_ADDR_C : RD_ADDR_C;
        lo_bank = RD_PRIO ? WR_BANK_C : RD_BANK_C;

        s_rst_n = 1'b0; init_end = 1'b0;
        wr_req = 1'b0; wr_end = 1'b0; rd_req = 1'b0; rd_end = 1'b0;
        setConstClients();
        repeat (3) nextCycle();

        for (int i = 0; i < 16; i++) begin
            nextCycle();
            applyStimulus(vecs[i]);
            if (vecs[i].restart) t0 = cyc;
            sample();
            case (vecs[i].sel)
                SEL_INIT: begin e_cmd = INIT_CMD_C; e_addr = INIT_ADDR_C; e_bank = 2'd0; end
                SEL_HI:   begin e_cmd = hi_cmd; e_addr = hi_addr; e_bank = hi_bank; end
                SEL_LO:   begin e_cmd = lo_cmd; e_addr = lo_addr; e_bank = lo_bank; end
                default:  begin e_cmd = CMD_NOP; e_addr = 12'h000; e_bank = 2'd0; end
            endcase
            checkOutput($sformatf("vec%0d_en_wr", i), en_wr, RD_PRIO ? vecs[i].exp_en_lo : vecs[i].exp_en_hi);
            checkOutput($sformatf("vec%0d_en_rd", i), en_rd, RD_PRIO ? vecs[i].exp_en_hi : vecs[i].exp_en_lo);
            checkOutput($sformatf("vec%0d_cmd", i), sdram_cmd, e_cmd);
            checkOutput($sformatf("vec%0d_addr", i), sdram_addr, e_addr);
            checkOutput($sformatf("vec%0d_bank", i), sdram_bank, e_bank);
            checkOutput($sformatf("vec%0d_req_aref", i), req_aref, 1'b0);
            checkOutput($sformatf("vec%0d_cke", i), sdram_cke, 1'b1);
        end

        // Idle arbiter: first refresh request and the full precharge/refresh sequence.
        nextCycle();
        waitReqAref(REF_CYCLES + 10, found);
        checkOutput("aref_first_rise_seen", found, 1'b1);
        checkOutput("aref_first_rise_delay", cyc - t0, REF_CYCLES);
        for (int p = 0; p < AREF_LEN; p++) begin
            nextCycle();
            sample();
            checkOutput($sformatf("aref_seq%0d_cmd", p), sdram_cmd, aref_seq[p]);
            checkOutput($sformatf("aref_seq%0d_addr", p), sdram_addr, (p == 0) ? 12'h400 : 12'h000);
            checkOutput($sformatf("aref_seq%0d_req", p), req_aref, 1'b1);
        end
        nextCycle();
        sample();
        checkOutput("aref_exit_cmd", sdram_cmd, CMD_NOP);
        checkOutput("aref_exit_req", req_aref, 1'b0);

        // Long read burst: refresh waits for rd_end, a second wrap flags a miss.
        nextCycle();
        rd_req = 1'b1;
        nextCycle();
        sample();
        checkOutput("rd_grant", en_rd, 1'b1);
        hold_ok = 1'b1;
        nextCycle();
        found = 1'b0;
        for (int k = 0; k < 2 * REF_CYCLES; k++) begin
            sample();
            hold_ok &= (en_rd === 1'b1) && (sdram_cmd === RD_CMD_C);
            if (req_aref === 1'b1) begin found = 1'b1; break; end
            nextCycle();
        end
        checkOutput("rd_burst_req_aref_seen", found, 1'b1);
        found = 1'b0;
        for (int k = 0; k < REF_CYCLES + 10; k++) begin
            nextCycle();
            sample();
            hold_ok &= (en_rd === 1'b1) && (req_aref === 1'b1);
            if (aref_miss === 1'b1) begin found = 1'b1; break; end
        end
        checkOutput("aref_miss_seen", found, 1'b1);
        checkOutput("rd_burst_held", hold_ok, 1'b1);
        nextCycle();
        rd_end = 1'b1;
        sample();
        checkOutput("rd_end_cycle_en_rd", en_rd, 1'b1);
        nextCycle();
        rd_end = 1'b0;
        sample();
        checkOutput("rd_release_en_rd", en_rd, 1'b0);
        checkOutput("rd_release_cmd", sdram_cmd, CMD_NOP);
        nextCycle();
        sample();
        checkOutput("rd_then_aref_cmd", sdram_cmd, CMD_PRE);
        hold_ok = (en_rd === 1'b0);
        repeat (AREF_LEN - 1) begin
            nextCycle();
            sample();
            hold_ok &= (en_rd === 1'b0);
        end
        checkOutput("rd_blocked_during_aref", hold_ok, 1'b1);
        nextCycle();
        sample();
        checkOutput("post_aref_arb_en_rd", en_rd, 1'b0);
        checkOutput("post_aref_req", req_aref, 1'b0);
        nextCycle();
        sample();
        checkOutput("rd_regrant", en_rd, 1'b1);
        checkOutput("rd_regrant_cmd", sdram_cmd, RD_CMD_C);
        checkOutput("aref_miss_sticky", aref_miss, 1'b1);
        nextCycle();
        rd_end = 1'b1; rd_req = 1'b0;
        nextCycle();
        rd_end = 1'b0;

        // Reset asserted at refresh step 5 returns to INIT and restarts the timer.
        found = 1'b0;
        for (int k = 0; k < REF_CYCLES + 30; k++) begin
            sample();
            if (sdram_cmd === CMD_PRE) begin found = 1'b1; break; end
            nextCycle();
        end
        checkOutput("second_aref_seen", found, 1'b1);
        repeat (5) nextCycle();
        s_rst_n = 1'b0;
        sample();
        checkOutput("aref_step5_cmd", sdram_cmd, CMD_NOP);
        nextCycle();
        s_rst_n = 1'b1;
        t0 = cyc;
        sample();
        checkOutput("rst_mid_aref_cmd", sdram_cmd, INIT_CMD_C);
        checkOutput("rst_mid_aref_req", req_aref, 1'b0);
        checkOutput("rst_mid_aref_miss", aref_miss, 1'b0);
        checkOutput("rst_mid_aref_en", {en_wr, en_rd}, 2'b00);
        nextCycle();
        sample();
        checkOutput("rst_then_arb_cmd", sdram_cmd, CMD_NOP);
        nextCycle();
        waitReqAref(REF_CYCLES + 10, found);
        checkOutput("rst_timer_restart_seen", found, 1'b1);
        checkOutput("rst_timer_restart_delay", cyc - t0, REF_CYCLES);

        // Randomized traffic against the reference model.
        nextCycle();
        s_rst_n = 1'b0;
        nextCycle();
        for (int k = 0; k < 5000; k++) begin
            nextCycle();
            s_rst_n   = ($urandom_range(0, 2999) != 0);
            init_end  = ($urandom_range(0, 1999) != 0);
            wr_req    = ($urandom_range(0, 2) == 0);
            rd_req    = ($urandom_range(0, 2) == 0);
            wr_end    = ($urandom_range(0, 15) == 0);
            rd_end    = ($urandom_range(0, 15) == 0);
            init_cmd  = 4'($urandom); init_addr = 12'($urandom);
            wr_cmd    = 4'($urandom); wr_addr   = 12'($urandom); wr_bank = 2'($urandom);
            rd_cmd    = 4'($urandom); rd_addr   = 12'($urandom); rd_bank = 2'($urandom);
            sample();
            checkOutput("rnd_en_wr", en_wr, m_owner == O_WR);
            checkOutput("rnd_en_rd", en_rd, m_owner == O_RD);
            checkOutput("rnd_req_aref", req_aref, m_pend);
            checkOutput("rnd_aref_miss", aref_miss, m_miss);
            checkOutput("rnd_cmd", sdram_cmd, expCmd());
            checkOutput("rnd_addr", sdram_addr, expAddr());
            checkOutput("rnd_bank", sdram_bank, expBank());
            checkOutput("rnd_cke", sdram_cke, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
